// File: rtl/wb_mem_port_arbiter_if.sv
// Wishbone bundle around the memory-port arbiter: packed per-requester vectors
// (requester i at [32i+31:32i] etc.) plus the single downstream port to memory.
interface wb_mem_port_arbiter_if #(
  parameter int masters = 2
);
  logic [32*masters-1:0] wb_m_adr_i;
  logic [32*masters-1:0] wb_m_dat_i;
  logic [4*masters-1:0]  wb_m_sel_i;
  logic [masters-1:0]    wb_m_cyc_i;
  logic [masters-1:0]    wb_m_stb_i;
  logic [masters-1:0]    wb_m_we_i;
  logic [3*masters-1:0]  wb_m_cti_i;
  logic [2*masters-1:0]  wb_m_bte_i;
  logic [masters-1:0]    wb_m_ack_o;
  logic [masters-1:0]    wb_m_err_o;
  logic [masters-1:0]    wb_m_rty_o;
  logic [31:0]           wb_m_dat_o;

  logic [31:0] wb_s_adr_o;
  logic [31:0] wb_s_dat_o;
  logic [3:0]  wb_s_sel_o;
  logic        wb_s_cyc_o;
  logic        wb_s_stb_o;
  logic        wb_s_we_o;
  logic [2:0]  wb_s_cti_o;
  logic [1:0]  wb_s_bte_o;
  logic        wb_s_ack_i;
  logic        wb_s_err_i;
  logic        wb_s_rty_i;
  logic [31:0] wb_s_dat_i;

  logic [masters-1:0] grant_o;

  // Arbiter view.
  modport slave (
    input  wb_m_adr_i, wb_m_dat_i, wb_m_sel_i, wb_m_cyc_i, wb_m_stb_i, wb_m_we_i,
    input  wb_m_cti_i, wb_m_bte_i,
    output wb_m_ack_o, wb_m_err_o, wb_m_rty_o, wb_m_dat_o,
    output wb_s_adr_o, wb_s_dat_o, wb_s_sel_o, wb_s_cyc_o, wb_s_stb_o, wb_s_we_o,
    output wb_s_cti_o, wb_s_bte_o,
    input  wb_s_ack_i, wb_s_err_i, wb_s_rty_i, wb_s_dat_i,
    output grant_o
  );

  // Environment view: requesters plus memory controller.
  modport master (
    output wb_m_adr_i, wb_m_dat_i, wb_m_sel_i, wb_m_cyc_i, wb_m_stb_i, wb_m_we_i,
    output wb_m_cti_i, wb_m_bte_i,
    input  wb_m_ack_o, wb_m_err_o, wb_m_rty_o, wb_m_dat_o,
    input  wb_s_adr_o, wb_s_dat_o, wb_s_sel_o, wb_s_cyc_o, wb_s_stb_o, wb_s_we_o,
    input  wb_s_cti_o, wb_s_bte_o,
    output wb_s_ack_i, wb_s_err_i, wb_s_rty_i, wb_s_dat_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_mem_port_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory master port; the owner keeps the
// bus for its whole cyc, and a watchdog aborts strobes the slave never answers.
module wb_mem_port_arbiter #(
  parameter int masters = 2,
  parameter int timeout = 255,
  parameter int tw      = 8
) (
  input logic                  clk,
  input logic                  rst,
  wb_mem_port_arbiter_if.slave bus
);
  localparam int              iw       = (masters > 1) ? $clog2(masters) : 1;
  localparam logic [iw-1:0]   last_rst = iw'(masters - 1);
  localparam logic [tw-1:0]   wdog_lim = tw'(timeout - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t             state_q, state_d;
  logic [masters-1:0] grant_q, grant_d;
  logic [iw-1:0]      last_q, last_d;
  logic [tw-1:0]      wdog_q, wdog_d;

  logic          found;
  logic [iw-1:0] pick;
  int            cand;
  logic          own_cyc, own_stb, resp, stalled, fire;

  // last_q doubles as the owner index while BUSY/ABORT.
  assign own_cyc = bus.wb_m_cyc_i[last_q];
  assign own_stb = bus.wb_m_stb_i[last_q];
  assign resp    = bus.wb_s_ack_i | bus.wb_s_err_i | bus.wb_s_rty_i;
  assign stalled = own_stb & ~resp;
  assign fire    = (state_q == BUSY) && stalled && (wdog_q == wdog_lim);

  assign bus.wb_m_dat_o = bus.wb_s_dat_i;
  assign bus.grant_o    = grant_q;

  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = 0;
    for (int k = 1; k <= masters; k++) begin
      cand = int'(last_q) + k;
      if (cand >= masters) cand = cand - masters;
      if (!found && bus.wb_m_cyc_i[cand]) begin
        found = 1'b1;
        pick  = cand[iw-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
        end
      end
      BUSY: begin
        if (fire) begin
          state_d = ABORT;
        end else if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (stalled) begin
          wdog_d = wdog_q + tw'(1);
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream port and responses follow the owner only during a live BUSY cycle.
  always_comb begin
    bus.wb_s_adr_o = '0;
    bus.wb_s_dat_o = '0;
    bus.wb_s_sel_o = '0;
    bus.wb_s_cyc_o = 1'b0;
    bus.wb_s_stb_o = 1'b0;
    bus.wb_s_we_o  = 1'b0;
    bus.wb_s_cti_o = '0;
    bus.wb_s_bte_o = '0;
    bus.wb_m_ack_o = '0;
    bus.wb_m_err_o = '0;
    bus.wb_m_rty_o = '0;
    if (state_q == BUSY) begin
      if (fire) begin
        bus.wb_m_err_o[last_q] = 1'b1;
      end else begin
        bus.wb_s_adr_o         = bus.wb_m_adr_i[32*last_q +: 32];
        bus.wb_s_dat_o         = bus.wb_m_dat_i[32*last_q +: 32];
        bus.wb_s_sel_o         = bus.wb_m_sel_i[4*last_q +: 4];
        bus.wb_s_cyc_o         = own_cyc;
        bus.wb_s_stb_o         = own_stb;
        bus.wb_s_we_o          = bus.wb_m_we_i[last_q];
        bus.wb_s_cti_o         = bus.wb_m_cti_i[3*last_q +: 3];
        bus.wb_s_bte_o         = bus.wb_m_bte_i[2*last_q +: 2];
        bus.wb_m_ack_o[last_q] = bus.wb_s_ack_i;
        bus.wb_m_err_o[last_q] = bus.wb_s_err_i;
        bus.wb_m_rty_o[last_q] = bus.wb_s_rty_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= last_rst;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Randomized scoreboard bench: requesters and memory are modelled at transaction level,
// expected bus activity and responses are queued and checked by a negedge monitor.
module tb_wb_mem_port_arbiter;
  localparam int MS         = 3;
  localparam int TO         = 16;
  localparam int RUN_CYCLES = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  bit   running = 1'b0;

  wb_mem_port_arbiter_if #(.masters(MS)) bus ();

  wb_mem_port_arbiter #(.masters(MS), .timeout(TO), .tw(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc_no;
    logic [MS-1:0] grant;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [31:0] m_dat;
  } bus_exp_t;

  typedef struct {
    int          cyc_no;
    int          master;
    int          kind;
    logic [31:0] dat;
    bit          is_read;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  // Requester models.
  bit          m_cyc[MS], m_stb[MS], m_we[MS], burst[MS];
  logic [31:0] m_adr[MS], m_dat[MS];
  logic [3:0]  m_sel[MS];
  logic [2:0]  m_cti[MS];
  logic [1:0]  m_bte[MS];
  int          beats_left[MS], idle_cnt[MS], done_kind[MS];

  // Memory contents and the arbitration reference (owner -1 means nobody).
  logic [31:0] mem[16];
  int          own, last, wd;
  bit          aborted, hang, force_start, busy_now;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_no);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(bus.grant_o), 32'd0);
    check({tag, "_s_cyc_stb"}, {30'd0, bus.wb_s_cyc_o, bus.wb_s_stb_o}, 32'd0);
    check({tag, "_s_adr"}, bus.wb_s_adr_o, 32'd0);
    check({tag, "_s_dat"}, bus.wb_s_dat_o, 32'd0);
    check({tag, "_s_ctl"}, {22'd0, bus.wb_s_we_o, bus.wb_s_sel_o, bus.wb_s_cti_o, bus.wb_s_bte_o}, 32'd0);
    check({tag, "_m_resp"}, 32'({bus.wb_m_ack_o, bus.wb_m_err_o, bus.wb_m_rty_o}), 32'd0);
  endtask

  task automatic model_reset();
    own = -1; last = MS - 1; wd = 0; aborted = 1'b0; hang = 1'b0; busy_now = 1'b0;
    force_start = 1'b1;
    for (int i = 0; i < MS; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; burst[i] = 1'b0;
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0; m_bte[i] = '0;
      beats_left[i] = 0; idle_cnt[i] = 0; done_kind[i] = 0;
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < MS; i++) begin
      bus.wb_m_adr_i[32*i +: 32] = m_adr[i];
      bus.wb_m_dat_i[32*i +: 32] = m_dat[i];
      bus.wb_m_sel_i[4*i +: 4]   = m_sel[i];
      bus.wb_m_cyc_i[i]          = m_cyc[i];
      bus.wb_m_stb_i[i]          = m_stb[i];
      bus.wb_m_we_i[i]           = m_we[i];
      bus.wb_m_cti_i[3*i +: 3]   = m_cti[i];
      bus.wb_m_bte_i[2*i +: 2]   = m_bte[i];
    end
  endtask

  task automatic set_beat(input int i, input bit first);
    if (!first) m_adr[i] = m_adr[i] + 32'd4;
    m_stb[i] = 1'b1;
    m_we[i]  = 1'($urandom_range(0, 1));
    m_dat[i] = $urandom();
    m_sel[i] = 4'($urandom_range(1, 15));
    m_cti[i] = !burst[i] ? 3'b000 : ((beats_left[i] == 1) ? 3'b111 : 3'b010);
    m_bte[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_masters();
    for (int i = 0; i < MS; i++) begin
      if (m_cyc[i]) begin
        if (done_kind[i] != 0) begin
          beats_left[i]--;
          if (done_kind[i] != 1 || beats_left[i] == 0) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            idle_cnt[i] = int'($urandom_range(0, 4));
          end else if ($urandom_range(0, 3) == 0) begin
            m_stb[i] = 1'b0;
          end else begin
            set_beat(i, 1'b0);
          end
          done_kind[i] = 0;
        end else if (!m_stb[i]) begin
          set_beat(i, 1'b0);
        end
      end else if ((force_start && i < 2) || (idle_cnt[i] == 0 && $urandom_range(0, 2) == 0)) begin
        m_cyc[i]      = 1'b1;
        beats_left[i] = int'($urandom_range(1, 4));
        burst[i]      = (beats_left[i] > 1);
        m_adr[i]      = ($urandom() & 32'hFFFF_FFC0) | ({28'd0, 4'($urandom_range(0, 15))} << 2);
        set_beat(i, 1'b1);
      end else if (idle_cnt[i] > 0) begin
        idle_cnt[i]--;
      end
    end
    force_start = 1'b0;
    pack_inputs();
  endtask

  // One cycle of the reference: expected port view, slave reply, and next owner.
  task automatic model_cycle();
    bus_exp_t    e;
    resp_exp_t   r;
    int          kind, idx, roll, nxt;
    logic [31:0] sdat;
    kind = 0;
    sdat = $urandom();
    busy_now = 1'b0;
    e.cyc_no = cyc_no;
    e.grant = '0;
    if (own >= 0) e.grant[own] = 1'b1;
    e.s_cyc = 1'b0; e.s_stb = 1'b0; e.s_we = 1'b0; e.s_adr = '0; e.s_dat = '0;
    e.s_sel = '0; e.s_cti = '0; e.s_bte = '0;
    if (own < 0 || aborted) begin
      if ($urandom_range(0, 7) == 0) kind = int'($urandom_range(1, 3));
      if (own < 0) begin
        for (int k = 1; k <= MS; k++) begin
          nxt = (last + k) % MS;
          if (m_cyc[nxt]) begin
            own = nxt; last = nxt; wd = 0;
            hang = ($urandom_range(0, 5) == 0);
            break;
          end
        end
      end else if (!m_cyc[own]) begin
        own = -1; aborted = 1'b0;
      end
    end else begin
      if (m_cyc[own] && m_stb[own] && !hang && $urandom_range(0, 2) != 0) begin
        idx  = int'(m_adr[own][5:2]);
        roll = int'($urandom_range(0, 9));
        kind = (roll == 0) ? 2 : ((roll == 1) ? 3 : 1);
        if (kind == 1 && !m_we[own]) sdat = mem[idx];
        if (kind == 1 && m_we[own]) begin
          for (int b = 0; b < 4; b++)
            if (m_sel[own][b]) mem[idx][8*b +: 8] = m_dat[own][8*b +: 8];
        end
      end
      if (m_stb[own] && kind == 0 && wd == TO - 1) begin
        r = '{cyc_no: cyc_no, master: own, kind: 2, dat: 32'd0, is_read: 1'b0};
        resp_q.push_back(r);
        done_kind[own] = 2;
        aborted = 1'b1;
        wd = 0;
      end else begin
        busy_now = m_cyc[own];
        e.s_cyc = m_cyc[own]; e.s_stb = m_stb[own]; e.s_we = m_we[own];
        e.s_adr = m_adr[own]; e.s_dat = m_dat[own]; e.s_sel = m_sel[own];
        e.s_cti = m_cti[own]; e.s_bte = m_bte[own];
        if (kind != 0) begin
          r = '{cyc_no: cyc_no, master: own, kind: kind, dat: sdat, is_read: !m_we[own]};
          resp_q.push_back(r);
          done_kind[own] = kind;
        end
        wd = (m_stb[own] && kind == 0) ? wd + 1 : 0;
        if (!m_cyc[own]) begin
          own = -1; wd = 0;
        end
      end
    end
    e.m_dat = sdat;
    bus.wb_s_ack_i = (kind == 1);
    bus.wb_s_err_i = (kind == 2);
    bus.wb_s_rty_i = (kind == 3);
    bus.wb_s_dat_i = sdat;
    bus_q.push_back(e);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    cyc_no++;
    #1;
    drive_masters();
    model_cycle();
  endtask

  task automatic checkOutput();
    bus_exp_t  e;
    resp_exp_t r;
    int        hits, who, want;
    if (bus_q.size() > 0 && bus_q[0].cyc_no == cyc_no) begin
      e = bus_q.pop_front();
      check("grant_o", 32'(bus.grant_o), 32'(e.grant));
      check("s_cyc_stb", {30'd0, bus.wb_s_cyc_o, bus.wb_s_stb_o}, {30'd0, e.s_cyc, e.s_stb});
      check("s_adr", bus.wb_s_adr_o, e.s_adr);
      check("s_dat", bus.wb_s_dat_o, e.s_dat);
      check("s_ctl", {22'd0, bus.wb_s_we_o, bus.wb_s_sel_o, bus.wb_s_cti_o, bus.wb_s_bte_o},
            {22'd0, e.s_we, e.s_sel, e.s_cti, e.s_bte});
      check("m_dat", bus.wb_m_dat_o, e.m_dat);
    end
    while (resp_q.size() > 0 && resp_q[0].cyc_no < cyc_no) begin
      r = resp_q.pop_front();
      checks++; errors++;
      $display("[TB] FAIL resp_missing: master %0d got no response, expected kind %0d at cycle %0d",
               r.master, r.kind, r.cyc_no);
    end
    hits = 0; who = -1;
    for (int i = 0; i < MS; i++) begin
      if (bus.wb_m_ack_o[i] | bus.wb_m_err_o[i] | bus.wb_m_rty_o[i]) begin
        hits++; who = i;
      end
    end
    if (hits > 0) begin
      if (resp_q.size() == 0 || resp_q[0].cyc_no != cyc_no) begin
        checks++; errors++;
        $display("[TB] FAIL resp_unexpected: master %0d got ack/err/rty=%b%b%b, expected none at cycle %0d",
                 who, bus.wb_m_ack_o[who], bus.wb_m_err_o[who], bus.wb_m_rty_o[who], cyc_no);
      end else begin
        r = resp_q.pop_front();
        want = (r.kind == 1) ? 4 : ((r.kind == 2) ? 2 : 1);
        check("resp_count", 32'(hits), 32'd1);
        check("resp_master", 32'(who), 32'(r.master));
        check("resp_kind", {29'd0, bus.wb_m_ack_o[who], bus.wb_m_err_o[who], bus.wb_m_rty_o[who]},
              32'(want));
        if (r.is_read && r.kind == 1) check("read_data", bus.wb_m_dat_o, r.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (running && !rst) checkOutput();
  end

  initial begin
    int budget;
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    model_reset();
    pack_inputs();
    bus.wb_s_ack_i = 1'b1;
    bus.wb_s_err_i = 1'b0;
    bus.wb_s_rty_i = 1'b0;
    bus.wb_s_dat_i = 32'h1234_5678;
    rst = 1'b1;
    #12;
    check_reset_outputs("reset");
    bus.wb_s_ack_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    running = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < RUN_CYCLES; n++) applyStimulus();
      if (phase == 0) begin
        budget = 0;
        do begin
          applyStimulus();
          budget++;
        end while (!busy_now && budget < 200);
        if (!busy_now) begin
          checks++; errors++;
          $display("[TB] FAIL busy_wait: no active transfer within %0d cycles, required one before mid-run reset", budget);
        end else begin
          #2;
          rst = 1'b1;
          bus_q.delete();
          resp_q.delete();
          #1;
          check_reset_outputs("async_reset");
          model_reset();
          pack_inputs();
          bus.wb_s_ack_i = 1'b0;
          bus.wb_s_err_i = 1'b0;
          bus.wb_s_rty_i = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    while (resp_q.size() > 0) begin
      resp_resp_drain();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic resp_resp_drain();
    resp_exp_t r;
    r = resp_q.pop_front();
    checks++; errors++;
    $display("[TB] FAIL resp_missing: master %0d got no response, expected kind %0d at cycle %0d",
             r.master, r.kind, r.cyc_no);
  endtask
endmodule

// File: doc/wb_mem_port_arbiter.md
Name: wb_mem_port_arbiter

Overview:
- Shares a memory tile's single external Wishbone master port (32-bit address/data, cti/bte bursts) between several Wishbone requesters.
- Typical requesters: the memory tile's NoC-side port and a host/debug loader.
- Round-robin arbiter with bus locking for the whole cyc_i duration, plus a watchdog that aborts stalled slave accesses.
- Sits between the requesters and the board memory controller.

Parameters:
- masters, 2, number of requesters (2..8).
- timeout, 255, max cycles a strobed access may wait for ack/err/rty before abort (>=2).
- tw, 8, watchdog counter width; must satisfy 2^tw > timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wb_m_adr_i  in  32*masters  requester addresses; requester i uses bits [32i+31:32i]; same packing for all vectors below
- wb_m_dat_i  in  32*masters  requester write data
- wb_m_sel_i  in  4*masters  byte selects
- wb_m_cyc_i  in  masters  cycle request
- wb_m_stb_i  in  masters  strobe
- wb_m_we_i  in  masters  write enable
- wb_m_cti_i  in  3*masters  cycle type
- wb_m_bte_i  in  2*masters  burst type
- wb_m_ack_o  out  masters  acknowledge
- wb_m_err_o  out  masters  error
- wb_m_rty_o  out  masters  retry
- wb_m_dat_o  out  32  read data, broadcast to all requesters
- wb_s_adr_o, wb_s_dat_o, wb_s_sel_o, wb_s_cyc_o, wb_s_stb_o, wb_s_we_o, wb_s_cti_o, wb_s_bte_o  out  32,32,4,1,1,1,3,2  to memory
- wb_s_ack_i, wb_s_err_i, wb_s_rty_i  in  1 each  slave responses
- wb_s_dat_i  in  32  slave read data
- grant_o  out  masters  one-hot current owner (status)

Behaviour:
- States: IDLE, BUSY, ABORT. Reset → IDLE.
- Reset values: grant=0, last-granted pointer=masters-1, watchdog=0; all wb_s_* outputs 0; all wb_m_ack/err/rty 0; grant_o=0.
- IDLE:
  - If any wb_m_cyc_i is set, pick the first requester in round-robin order starting at (last+1) mod masters.
  - Register it as grant and pointer; go to BUSY next cycle.
  - Latency: cyc_i rising → wb_s_cyc_o high one cycle later.
- BUSY:
  - All wb_s_* outputs combinationally muxed from the granted requester.
  - Slave ack/err/rty routed only to the granted requester; others see 0.
  - wb_s_dat_i passed to wb_m_dat_o unconditionally.
  - Granted requester keeps the bus for the whole time cyc_i stays high, including multi-beat bursts (cti 001/010) and idle stb gaps.
  - Granted cyc_i low → IDLE next cycle. This gives one dead cycle between owners; no back-to-back grant.
- Watchdog:
  - In BUSY, counts cycles with granted stb high and no slave ack/err/rty.
  - Cleared on any response or stb low.
  - When the count reaches timeout:
    - wb_m_err_o of the owner pulses for one cycle.
    - wb_s_cyc_o and wb_s_stb_o forced 0 that cycle.
    - Go to ABORT.
  - Slave responses arriving in that same cycle are discarded.
- ABORT:
  - wb_s_cyc_o/stb_o held 0; owner gets no further responses.
  - Stays until owner drops cyc_i, then IDLE.
- Simultaneous events:
  - Requests arriving while BUSY wait; they are not queued, only resampled in IDLE.
  - Owner dropping cyc_i in the same cycle the slave acks: ack still delivered combinationally, then IDLE.
- Reset asserted mid-transfer: everything returns to reset values immediately (asynchronous); the slave sees cyc drop without completion.
- Non-granted requesters: ack/err/rty are always 0, and their inputs are ignored.

Test Plan:
- Single-read: M0 cyc/stb/adr=0x100, slave acks at cycle 3 with dat 0xCAFEF00D → wb_s_cyc_o high 1 cycle after cyc_i; M0 ack with dat 0xCAFEF00D; IDLE after M0 drops cyc.
- Contention: M0 and M1 raise cyc in the same cycle after reset → M0 granted (grant_o=01); M1 granted (grant_o=10) exactly 2 cycles after M0 drops cyc.
- Fairness: M0 and M1 issue continuous single-beat cycles for 20 transactions → grants alternate 0,1,0,1...; each requester gets 10.
- Burst lock: M1 runs a 4-beat incrementing burst (cti 010,010,010,111) while M0 requests → M0 sees no ack and grant_o stays 10 until M1 drops cyc after beat 4.
- Timeout: timeout=16, slave never responds to M0 → M0 err pulses exactly one cycle on the 16th stalled cycle; wb_s_cyc_o is 0 from then on; after M0 drops cyc, M1 is granted normally.
- Reset mid-burst: assert rst during beat 2 → all wb_s_* and wb_m_* outputs 0 immediately; after release, M0 request is granted first.
